// File: rtl/cci_mpf_c0_rd_arb.sv
// cci_mpf_c0_rd_arb
//   Two-port round-robin arbiter for CCI c0 read-line requests with
//   per-port in-flight tracking and response routing. The MSB of the
//   metadata tag carries the originating port through the FIU.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   rqN_valid/addr/mdata       requester N read request (N = 0,1)
//   rqN_grant                  combinational accept for requester N
//   fiu_tx_valid/addr/mdata    registered read request toward FIU
//   fiu_tx_alm_full            FIU c0 request channel almost full
//   fiu_rx_valid/mdata/data    read response from FIU
//   rsN_valid/mdata/data       registered response routed to requester N
//   err_mdata                  sticky: request seen with tag MSB set
//   err_underflow              sticky: response for port with none in flight
module cci_mpf_c0_rd_arb #(
    parameter int unsigned ADDR_WIDTH      = 42,
    parameter int unsigned MDATA_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned MAX_OUTSTANDING = 32
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   rq0_valid,
    input  logic [ADDR_WIDTH-1:0]  rq0_addr,
    input  logic [MDATA_WIDTH-1:0] rq0_mdata,
    output logic                   rq0_grant,
    input  logic                   rq1_valid,
    input  logic [ADDR_WIDTH-1:0]  rq1_addr,
    input  logic [MDATA_WIDTH-1:0] rq1_mdata,
    output logic                   rq1_grant,

    output logic                   fiu_tx_valid,
    output logic [ADDR_WIDTH-1:0]  fiu_tx_addr,
    output logic [MDATA_WIDTH-1:0] fiu_tx_mdata,
    input  logic                   fiu_tx_alm_full,

    input  logic                   fiu_rx_valid,
    input  logic [MDATA_WIDTH-1:0] fiu_rx_mdata,
    input  logic [DATA_WIDTH-1:0]  fiu_rx_data,

    output logic                   rs0_valid,
    output logic [MDATA_WIDTH-1:0] rs0_mdata,
    output logic [DATA_WIDTH-1:0]  rs0_data,
    output logic                   rs1_valid,
    output logic [MDATA_WIDTH-1:0] rs1_mdata,
    output logic [DATA_WIDTH-1:0]  rs1_data,

    output logic                   err_mdata,
    output logic                   err_underflow
);

    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned MSB = MDATA_WIDTH - 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [1:0]             rq_valid;
    logic [1:0]             elig;
    logic [1:0]             grant;
    logic [1:0]             rsp_hit;

    logic                   rr_q, rr_d;
    logic [CW-1:0]          cnt_q [2];
    logic [CW-1:0]          cnt_d [2];

    logic                   tx_valid_q, tx_valid_d;
    logic [ADDR_WIDTH-1:0]  tx_addr_q, tx_addr_d;
    logic [MDATA_WIDTH-1:0] tx_mdata_q, tx_mdata_d;

    logic                   rs0_valid_q, rs0_valid_d;
    logic [MDATA_WIDTH-1:0] rs0_mdata_q, rs0_mdata_d;
    logic [DATA_WIDTH-1:0]  rs0_data_q, rs0_data_d;
    logic                   rs1_valid_q, rs1_valid_d;
    logic [MDATA_WIDTH-1:0] rs1_mdata_q, rs1_mdata_d;
    logic [DATA_WIDTH-1:0]  rs1_data_q, rs1_data_d;

    logic                   err_mdata_q, err_mdata_d;
    logic                   err_underflow_q, err_underflow_d;

    assign rq_valid   = {rq1_valid, rq0_valid};
    assign rsp_hit[0] = fiu_rx_valid & ~fiu_rx_mdata[MSB];
    assign rsp_hit[1] = fiu_rx_valid &  fiu_rx_mdata[MSB];

    // Arbitration: a lone eligible port wins outright; a tie goes to rr.
    // Grants are forced low while reset is held.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            elig[i] = ~reset & rq_valid[i] & ~fiu_tx_alm_full & (cnt_q[i] < MAX_CNT);
        end
        grant[0] = elig[0] & (~elig[1] | ~rr_q);
        grant[1] = elig[1] & (~elig[0] |  rr_q);
    end

    assign rq0_grant = grant[0];
    assign rq1_grant = grant[1];

    always_comb begin
        rr_d = rr_q;
        if (grant[0])      rr_d = 1'b1;
        else if (grant[1]) rr_d = 1'b0;

        tx_valid_d = |grant;
        tx_addr_d  = tx_addr_q;
        tx_mdata_d = tx_mdata_q;
        if (grant[0]) begin
            tx_addr_d  = rq0_addr;
            tx_mdata_d = {1'b0, rq0_mdata[MSB-1:0]};
        end else if (grant[1]) begin
            tx_addr_d  = rq1_addr;
            tx_mdata_d = {1'b1, rq1_mdata[MSB-1:0]};
        end
    end

    // In-flight counters. A response hitting an empty counter is flagged
    // but the counter is clamped at zero; grant+response cancel out.
    always_comb begin
        err_underflow_d = err_underflow_q;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !rsp_hit[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (rsp_hit[i] && !grant[i]) begin
                if (cnt_q[i] == '0) err_underflow_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        err_mdata_d = err_mdata_q | (rq0_valid & rq0_mdata[MSB]) | (rq1_valid & rq1_mdata[MSB]);
    end

    always_comb begin
        rs0_valid_d = rsp_hit[0];
        rs0_mdata_d = rs0_mdata_q;
        rs0_data_d  = rs0_data_q;
        rs1_valid_d = rsp_hit[1];
        rs1_mdata_d = rs1_mdata_q;
        rs1_data_d  = rs1_data_q;
        if (rsp_hit[0]) begin
            rs0_mdata_d = {1'b0, fiu_rx_mdata[MSB-1:0]};
            rs0_data_d  = fiu_rx_data;
        end
        if (rsp_hit[1]) begin
            rs1_mdata_d = {1'b0, fiu_rx_mdata[MSB-1:0]};
            rs1_data_d  = fiu_rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q            <= 1'b0;
            cnt_q[0]        <= '0;
            cnt_q[1]        <= '0;
            tx_valid_q      <= 1'b0;
            tx_addr_q       <= '0;
            tx_mdata_q      <= '0;
            rs0_valid_q     <= 1'b0;
            rs0_mdata_q     <= '0;
            rs0_data_q      <= '0;
            rs1_valid_q     <= 1'b0;
            rs1_mdata_q     <= '0;
            rs1_data_q      <= '0;
            err_mdata_q     <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            rr_q            <= rr_d;
            cnt_q[0]        <= cnt_d[0];
            cnt_q[1]        <= cnt_d[1];
            tx_valid_q      <= tx_valid_d;
            tx_addr_q       <= tx_addr_d;
            tx_mdata_q      <= tx_mdata_d;
            rs0_valid_q     <= rs0_valid_d;
            rs0_mdata_q     <= rs0_mdata_d;
            rs0_data_q      <= rs0_data_d;
            rs1_valid_q     <= rs1_valid_d;
            rs1_mdata_q     <= rs1_mdata_d;
            rs1_data_q      <= rs1_data_d;
            err_mdata_q     <= err_mdata_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign fiu_tx_valid  = tx_valid_q;
    assign fiu_tx_addr   = tx_addr_q;
    assign fiu_tx_mdata  = tx_mdata_q;
    assign rs0_valid     = rs0_valid_q;
    assign rs0_mdata     = rs0_mdata_q;
    assign rs0_data      = rs0_data_q;
    assign rs1_valid     = rs1_valid_q;
    assign rs1_mdata     = rs1_mdata_q;
    assign rs1_data      = rs1_data_q;
    assign err_mdata     = err_mdata_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_cci_mpf_c0_rd_arb.sv
// Directed testbench for cci_mpf_c0_rd_arb (MAX_OUTSTANDING = 4).
// Inputs change and outputs are sampled 1-2 time units after each rising edge.
module tb_cci_mpf_c0_rd_arb;

    localparam int unsigned AW = 42;
    localparam int unsigned MW = 16;
    localparam int unsigned DW = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          rq0_valid, rq1_valid;
    logic [AW-1:0] rq0_addr, rq1_addr;
    logic [MW-1:0] rq0_mdata, rq1_mdata;
    logic          rq0_grant, rq1_grant;
    logic          fiu_tx_valid;
    logic [AW-1:0] fiu_tx_addr;
    logic [MW-1:0] fiu_tx_mdata;
    logic          fiu_tx_alm_full;
    logic          fiu_rx_valid;
    logic [MW-1:0] fiu_rx_mdata;
    logic [DW-1:0] fiu_rx_data;
    logic          rs0_valid, rs1_valid;
    logic [MW-1:0] rs0_mdata, rs1_mdata;
    logic [DW-1:0] rs0_data, rs1_data;
    logic          err_mdata, err_underflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cci_mpf_c0_rd_arb #(
        .ADDR_WIDTH(AW), .MDATA_WIDTH(MW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .reset(reset),
        .rq0_valid(rq0_valid), .rq0_addr(rq0_addr), .rq0_mdata(rq0_mdata), .rq0_grant(rq0_grant),
        .rq1_valid(rq1_valid), .rq1_addr(rq1_addr), .rq1_mdata(rq1_mdata), .rq1_grant(rq1_grant),
        .fiu_tx_valid(fiu_tx_valid), .fiu_tx_addr(fiu_tx_addr), .fiu_tx_mdata(fiu_tx_mdata),
        .fiu_tx_alm_full(fiu_tx_alm_full),
        .fiu_rx_valid(fiu_rx_valid), .fiu_rx_mdata(fiu_rx_mdata), .fiu_rx_data(fiu_rx_data),
        .rs0_valid(rs0_valid), .rs0_mdata(rs0_mdata), .rs0_data(rs0_data),
        .rs1_valid(rs1_valid), .rs1_mdata(rs1_mdata), .rs1_data(rs1_data),
        .err_mdata(err_mdata), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rq0_valid = 1'b0; rq0_addr = '0; rq0_mdata = '0;
        rq1_valid = 1'b0; rq1_addr = '0; rq1_mdata = '0;
        fiu_tx_alm_full = 1'b0;
        fiu_rx_valid = 1'b0; fiu_rx_mdata = '0; fiu_rx_data = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        rq0_valid = 1'b1; rq1_valid = 1'b1;
        fiu_rx_valid = 1'b1; fiu_rx_mdata = 16'h8001;
        #1;
        total_cnt++; if (rq0_grant !== 1'b0) $display("FAIL rst_g0: got %b want 0", rq0_grant); else pass_cnt++;
        total_cnt++; if (rq1_grant !== 1'b0) $display("FAIL rst_g1: got %b want 0", rq1_grant); else pass_cnt++;
        tick();
        total_cnt++; if (fiu_tx_valid !== 1'b0) $display("FAIL rst_txv: got %b want 0", fiu_tx_valid); else pass_cnt++;
        total_cnt++; if (rs0_valid !== 1'b0) $display("FAIL rst_rs0v: got %b want 0", rs0_valid); else pass_cnt++;
        total_cnt++; if (rs1_valid !== 1'b0) $display("FAIL rst_rs1v: got %b want 0", rs1_valid); else pass_cnt++;
        total_cnt++; if (err_mdata !== 1'b0) $display("FAIL rst_errm: got %b want 0", err_mdata); else pass_cnt++;
        total_cnt++; if (err_underflow !== 1'b0) $display("FAIL rst_erru: got %b want 0", err_underflow); else pass_cnt++;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    // Both ports requesting continuously: 0,1,0,1,... with one-cycle issue latency.
    task automatic test_back_to_back;
        logic          exp0;
        logic [MW-1:0] exp_md;
        logic [AW-1:0] exp_ad;
        do_reset();
        rq0_valid = 1'b1; rq0_addr = 42'h0AA_0000_0000; rq0_mdata = 16'h0011;
        rq1_valid = 1'b1; rq1_addr = 42'h155_0000_0001; rq1_mdata = 16'h0022;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp0 = (i % 2 == 0);
            total_cnt++; if (rq0_grant !== exp0) $display("FAIL b2b_g0[%0d]: got %b want %b", i, rq0_grant, exp0); else pass_cnt++;
            total_cnt++; if (rq1_grant !== !exp0) $display("FAIL b2b_g1[%0d]: got %b want %b", i, rq1_grant, !exp0); else pass_cnt++;
            if (i == 0) begin
                total_cnt++; if (fiu_tx_valid !== 1'b0) $display("FAIL b2b_txv0: got %b want 0", fiu_tx_valid); else pass_cnt++;
            end else begin
                exp_md = (i % 2 == 1) ? 16'h0011 : 16'h8022;
                exp_ad = (i % 2 == 1) ? 42'h0AA_0000_0000 : 42'h155_0000_0001;
                total_cnt++; if (fiu_tx_valid !== 1'b1) $display("FAIL b2b_txv[%0d]: got %b want 1", i, fiu_tx_valid); else pass_cnt++;
                total_cnt++; if (fiu_tx_mdata !== exp_md) $display("FAIL b2b_txmd[%0d]: got %h want %h", i, fiu_tx_mdata, exp_md); else pass_cnt++;
                total_cnt++; if (fiu_tx_addr !== exp_ad) $display("FAIL b2b_txad[%0d]: got %h want %h", i, fiu_tx_addr, exp_ad); else pass_cnt++;
            end
            tick();
        end
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        #1;
        total_cnt++; if (fiu_tx_mdata !== 16'h8022) $display("FAIL b2b_last: got %h want 8022", fiu_tx_mdata); else pass_cnt++;
        tick();
        total_cnt++; if (fiu_tx_valid !== 1'b0) $display("FAIL b2b_idle_v: got %b want 0", fiu_tx_valid); else pass_cnt++;
        total_cnt++; if (fiu_tx_mdata !== 16'h8022) $display("FAIL b2b_hold_md: got %h want 8022", fiu_tx_mdata); else pass_cnt++;
    endtask

    // Port 0 alone stalls after 4 in flight; one response reopens it.
    task automatic test_limit;
        logic [DW-1:0] d;
        d = {16{32'hCAFE_0003}};
        do_reset();
        rq0_valid = 1'b1; rq0_addr = 42'h3; rq0_mdata = 16'h0003;
        for (int i = 0; i < 6; i++) begin
            #1;
            total_cnt++; if (rq0_grant !== (i < 4)) $display("FAIL lim_g0[%0d]: got %b want %b", i, rq0_grant, (i < 4)); else pass_cnt++;
            tick();
        end
        fiu_rx_valid = 1'b1; fiu_rx_mdata = 16'h0003; fiu_rx_data = d;
        #1;
        total_cnt++; if (rq0_grant !== 1'b0) $display("FAIL lim_g0_rsp: got %b want 0", rq0_grant); else pass_cnt++;
        tick();
        fiu_rx_valid = 1'b0;
        #1;
        total_cnt++; if (rq0_grant !== 1'b1) $display("FAIL lim_resume: got %b want 1", rq0_grant); else pass_cnt++;
        total_cnt++; if (rs0_valid !== 1'b1) $display("FAIL lim_rs0v: got %b want 1", rs0_valid); else pass_cnt++;
        total_cnt++; if (rs0_mdata !== 16'h0003) $display("FAIL lim_rs0md: got %h want 0003", rs0_mdata); else pass_cnt++;
        total_cnt++; if (rs0_data !== d) $display("FAIL lim_rs0d: got %h want %h", rs0_data, d); else pass_cnt++;
        total_cnt++; if (rs1_valid !== 1'b0) $display("FAIL lim_rs1v: got %b want 0", rs1_valid); else pass_cnt++;
        tick();
        rq0_valid = 1'b0;
        #1;
        total_cnt++; if (rq0_grant !== 1'b0) $display("FAIL lim_full_again: got %b want 0", rq0_grant); else pass_cnt++;
        total_cnt++; if (rs0_valid !== 1'b0) $display("FAIL lim_rs0v_drop: got %b want 0", rs0_valid); else pass_cnt++;
    endtask

    task automatic test_alm_full;
        do_reset();
        rq0_valid = 1'b1; rq0_mdata = 16'h0001; rq0_addr = 42'h10;
        rq1_valid = 1'b1; rq1_mdata = 16'h0002; rq1_addr = 42'h20;
        #1;
        total_cnt++; if (rq0_grant !== 1'b1) $display("FAIL af_pre_g0: got %b want 1", rq0_grant); else pass_cnt++;
        tick();
        fiu_tx_alm_full = 1'b1;
        #1;
        total_cnt++; if ({rq1_grant, rq0_grant} !== 2'b00) $display("FAIL af_g: got %b want 00", {rq1_grant, rq0_grant}); else pass_cnt++;
        total_cnt++; if (fiu_tx_valid !== 1'b1) $display("FAIL af_nocancel: got %b want 1", fiu_tx_valid); else pass_cnt++;
        total_cnt++; if (fiu_tx_mdata !== 16'h0001) $display("FAIL af_md: got %h want 0001", fiu_tx_mdata); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if ({rq1_grant, rq0_grant} !== 2'b00) $display("FAIL af_g2: got %b want 00", {rq1_grant, rq0_grant}); else pass_cnt++;
        total_cnt++; if (fiu_tx_valid !== 1'b0) $display("FAIL af_txv: got %b want 0", fiu_tx_valid); else pass_cnt++;
        fiu_tx_alm_full = 1'b0;
        #1;
        total_cnt++; if ({rq1_grant, rq0_grant} !== 2'b10) $display("FAIL af_release: got %b want 10", {rq1_grant, rq0_grant}); else pass_cnt++;
        tick();
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        total_cnt++; if (fiu_tx_mdata !== 16'h8002) $display("FAIL af_md1: got %h want 8002", fiu_tx_mdata); else pass_cnt++;
    endtask

    task automatic test_underflow;
        logic [DW-1:0] d;
        d = {8{64'h0123_4567_89AB_CDEF}};
        do_reset();
        fiu_rx_valid = 1'b1; fiu_rx_mdata = 16'h8005; fiu_rx_data = d;
        tick();
        fiu_rx_valid = 1'b0;
        total_cnt++; if (rs1_valid !== 1'b1) $display("FAIL uf_rs1v: got %b want 1", rs1_valid); else pass_cnt++;
        total_cnt++; if (rs1_mdata !== 16'h0005) $display("FAIL uf_rs1md: got %h want 0005", rs1_mdata); else pass_cnt++;
        total_cnt++; if (rs1_data !== d) $display("FAIL uf_rs1d: got %h want %h", rs1_data, d); else pass_cnt++;
        total_cnt++; if (rs0_valid !== 1'b0) $display("FAIL uf_rs0v: got %b want 0", rs0_valid); else pass_cnt++;
        total_cnt++; if (err_underflow !== 1'b1) $display("FAIL uf_err: got %b want 1", err_underflow); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (err_underflow !== 1'b1) $display("FAIL uf_sticky: got %b want 1", err_underflow); else pass_cnt++;
        total_cnt++; if (rs1_valid !== 1'b0) $display("FAIL uf_rs1v_drop: got %b want 0", rs1_valid); else pass_cnt++;
        // Counter must have stayed at zero: exactly 4 grants follow.
        rq1_valid = 1'b1; rq1_mdata = 16'h0006;
        for (int i = 0; i < 6; i++) begin
            #1;
            total_cnt++; if (rq1_grant !== (i < 4)) $display("FAIL uf_cnt_g1[%0d]: got %b want %b", i, rq1_grant, (i < 4)); else pass_cnt++;
            tick();
        end
        rq1_valid = 1'b0;
    endtask

    task automatic test_same_cycle;
        do_reset();
        rq1_valid = 1'b1; rq1_mdata = 16'h0009;
        #1;
        total_cnt++; if (rq1_grant !== 1'b1) $display("FAIL sc_g1a: got %b want 1", rq1_grant); else pass_cnt++;
        tick();
        fiu_rx_valid = 1'b1; fiu_rx_mdata = 16'h8001;
        #1;
        total_cnt++; if (rq1_grant !== 1'b1) $display("FAIL sc_g1b: got %b want 1", rq1_grant); else pass_cnt++;
        tick();
        fiu_rx_valid = 1'b0;
        total_cnt++; if (rs1_mdata !== 16'h0001) $display("FAIL sc_rs1md: got %h want 0001", rs1_mdata); else pass_cnt++;
        // One in flight remains, so three more grants fit.
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if (rq1_grant !== (i < 3)) $display("FAIL sc_g1[%0d]: got %b want %b", i, rq1_grant, (i < 3)); else pass_cnt++;
            tick();
        end
        rq1_valid = 1'b0;
        total_cnt++; if (err_underflow !== 1'b0) $display("FAIL sc_erru: got %b want 0", err_underflow); else pass_cnt++;
    endtask

    task automatic test_err_mdata;
        do_reset();
        rq0_valid = 1'b1; rq0_mdata = 16'h8007;
        #1;
        total_cnt++; if (rq0_grant !== 1'b1) $display("FAIL em_g0: got %b want 1", rq0_grant); else pass_cnt++;
        total_cnt++; if (err_mdata !== 1'b0) $display("FAIL em_pre: got %b want 0", err_mdata); else pass_cnt++;
        tick();
        rq0_valid = 1'b0;
        total_cnt++; if (err_mdata !== 1'b1) $display("FAIL em_set: got %b want 1", err_mdata); else pass_cnt++;
        total_cnt++; if (fiu_tx_mdata !== 16'h0007) $display("FAIL em_txmd: got %h want 0007", fiu_tx_mdata); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (err_mdata !== 1'b1) $display("FAIL em_sticky: got %b want 1", err_mdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        rq0_valid = 1'b1; rq0_mdata = 16'h8001;
        rq1_valid = 1'b1; rq1_mdata = 16'h0002;
        fiu_rx_valid = 1'b1; fiu_rx_mdata = 16'h8003;
        tick(); tick(); tick();
        total_cnt++; if (fiu_tx_valid !== 1'b1) $display("FAIL rm_pre_txv: got %b want 1", fiu_tx_valid); else pass_cnt++;
        total_cnt++; if (rs1_valid !== 1'b1) $display("FAIL rm_pre_rs1v: got %b want 1", rs1_valid); else pass_cnt++;
        total_cnt++; if ({err_mdata, err_underflow} !== 2'b11) $display("FAIL rm_pre_err: got %b want 11", {err_mdata, err_underflow}); else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++; if (fiu_tx_valid !== 1'b0) $display("FAIL rm_txv: got %b want 0", fiu_tx_valid); else pass_cnt++;
        total_cnt++; if ({rs1_valid, rs0_valid} !== 2'b00) $display("FAIL rm_rsv: got %b want 00", {rs1_valid, rs0_valid}); else pass_cnt++;
        total_cnt++; if ({err_mdata, err_underflow} !== 2'b00) $display("FAIL rm_err: got %b want 00", {err_mdata, err_underflow}); else pass_cnt++;
        total_cnt++; if ({rq1_grant, rq0_grant} !== 2'b00) $display("FAIL rm_g: got %b want 00", {rq1_grant, rq0_grant}); else pass_cnt++;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        // rr was 1 before reset; a tie right after release must go to port 0.
        rq0_valid = 1'b1; rq0_mdata = 16'h0004;
        rq1_valid = 1'b1; rq1_mdata = 16'h0005;
        #1;
        total_cnt++; if ({rq1_grant, rq0_grant} !== 2'b01) $display("FAIL rm_first: got %b want 01", {rq1_grant, rq0_grant}); else pass_cnt++;
        tick();
        rq1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if (rq0_grant !== (i < 3)) $display("FAIL rm_cnt_g0[%0d]: got %b want %b", i, rq0_grant, (i < 3)); else pass_cnt++;
            tick();
        end
        rq0_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        #2;
        test_reset();
        test_back_to_back();
        test_limit();
        test_alm_full();
        test_underflow();
        test_same_cycle();
        test_err_mdata();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
